// File: rtl/wb_rom_if.sv
// wb_rom_if: Wishbone classic slave bus between the management core and the ROM port bridge.
interface wb_rom_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_rom_port.sv
// wb_rom_port: Wishbone slave driving port 0 of the 32x512 program-store SRAM, one SRAM access per bus cycle.
// Define WB_ROM_READBACK_EN to build the SRAM read path; otherwise reads ack immediately with zero data.
module wb_rom_port #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter logic [31:0] ADR_MASK = 32'hFFFF_F800
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    wb_rom_if.slave     bus,
    input  logic        rom_lock,
    output logic        wb_rom_csb,
    output logic        wb_rom_web,
    output logic [8:0]  wb_rom_adrb,
    output logic [3:0]  wb_rom_wmask,
    output logic [31:0] wb_rom_din,
    input  logic [31:0] wb_rom_val
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR      = 3'd1;
    localparam logic [2:0] ACK     = 3'd4;
`ifdef WB_ROM_READBACK_EN
    localparam logic [2:0] RD      = 3'd2;
    localparam logic [2:0] RD_WAIT = 3'd3;
`else
    logic unused_val;
    assign unused_val = ^wb_rom_val;
`endif
    logic [2:0]  state_q, state_d;
    logic        ack_q, ack_d, csb_q, csb_d, web_q, web_d;
    logic [31:0] dat_q, dat_d, din_q, din_d;
    logic [8:0]  adrb_q, adrb_d;
    logic [3:0]  wmask_q, wmask_d;
    logic        hit;
    assign hit = bus.wbs_cyc_i & bus.wbs_stb_i & ((bus.wbs_adr_i & ADR_MASK) == BASE_ADR);
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        dat_d   = dat_q;
        csb_d   = csb_q;
        web_d   = web_q;
        adrb_d  = adrb_q;
        wmask_d = wmask_q;
        din_d   = din_q;
        case (state_q)
            IDLE: if (hit) begin
                adrb_d  = bus.wbs_adr_i[10:2];
                din_d   = bus.wbs_dat_i;
                wmask_d = bus.wbs_sel_i;
                if (bus.wbs_we_i) begin
                    // A locked write still handshakes but never touches the macro.
                    state_d = WR;
                    csb_d   = rom_lock;
                    web_d   = rom_lock;
                end else begin
`ifdef WB_ROM_READBACK_EN
                    state_d = RD;
                    csb_d   = 1'b0;
                    web_d   = 1'b1;
`else
                    state_d = ACK;
                    ack_d   = 1'b1;
`endif
                end
            end
            WR: begin
                csb_d   = 1'b1;
                web_d   = 1'b1;
                ack_d   = bus.wbs_cyc_i;
                state_d = bus.wbs_cyc_i ? ACK : IDLE;
            end
`ifdef WB_ROM_READBACK_EN
            RD: begin
                csb_d   = 1'b1;
                web_d   = 1'b1;
                state_d = bus.wbs_cyc_i ? RD_WAIT : IDLE;
            end
            RD_WAIT: begin
                ack_d   = bus.wbs_cyc_i;
                dat_d   = bus.wbs_cyc_i ? wb_rom_val : dat_q;
                state_d = bus.wbs_cyc_i ? ACK : IDLE;
            end
`endif
            ACK: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
                csb_d   = 1'b1;
                web_d   = 1'b1;
            end
        endcase
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            adrb_q  <= '0;
            wmask_q <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            adrb_q  <= adrb_d;
            wmask_q <= wmask_d;
            din_q   <= din_d;
        end
    end
    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_dat_o = dat_q;
    assign wb_rom_csb    = csb_q;
    assign wb_rom_web    = web_q;
    assign wb_rom_adrb   = adrb_q;
    assign wb_rom_wmask  = wmask_q;
    assign wb_rom_din    = din_q;
endmodule

// File: doc/wb_rom_port.md
# wb_rom_port

Wishbone slave bridge between the Caravel management bus and port 0 (read/write) of the 2 kB OpenRAM program-store macro (32×512). It lets firmware load and optionally read back TMS1x00 program ROM contents while the core fetches from port 1, and drives the macro's `wb_rom_*` nets directly. A small FSM sequences chip-select, write-enable and the registered acknowledge so that every Wishbone cycle maps to exactly one SRAM access.

## Interface
Parameters:
- `BASE_ADR`, default 32'h3000_0000: base of the ROM window.
- `ADR_MASK`, default 32'hFFFF_F800: window mask (2 kB).

Ports:
- `wb_clk_i`  in  1  clock; also clocks SRAM port 0.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1  Wishbone classic controls.
- `wbs_sel_i`  in  4  byte-lane enables.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  acknowledge, registered.
- `wbs_dat_o`  out  32  read data, registered.
- `rom_lock`  in  1  when high, window writes are acked but not performed.
- `wb_rom_csb`  out  1  SRAM port 0 chip select, active-low.
- `wb_rom_web`  out  1  SRAM port 0 write enable, active-low.
- `wb_rom_adrb`  out  9  SRAM word address.
- `wb_rom_wmask`  out  4  SRAM byte mask.
- `wb_rom_din`  out  32  SRAM write data.
- `wb_rom_val`  in  32  SRAM port 0 read data.

## Operation
- Hit = `wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADR_MASK) == BASE_ADR)`. No response to misses.
- Address mapping: `wb_rom_adrb = wbs_adr_i[10:2]`. Bits [1:0] are ignored.
- All SRAM-side outputs are registered and loaded in IDLE on a hit: adrb, din ← `wbs_dat_i`, wmask ← `wbs_sel_i`.
- FSM states: IDLE, WR, RD, RD_WAIT, ACK.
  - IDLE + hit + we: go to WR. csb=0; web = `rom_lock` (lock keeps web=1 and csb=1, so no SRAM access occurs).
  - IDLE + hit + !we: go to RD. csb=0, web=1.
  - WR: go to ACK. csb←1, web←1, ack←1.
  - RD: go to RD_WAIT. csb←1.
  - RD_WAIT: `wbs_dat_o` ← `wb_rom_val`, ack←1, go to ACK.
  - ACK: ack←0, go to IDLE. `wbs_dat_o` holds its value until the next read capture.
- Abort: if `wbs_cyc_i` is low in WR, RD or RD_WAIT, go to IDLE with csb=1, web=1 and no ack. An SRAM access already issued is allowed to complete.
- `wbs_sel_i`=0 on a write is still a full handshake; the mask is 0, so no bytes change.
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `wb_rom_csb`=1, `wb_rom_web`=1, adrb/wmask/din=0, state IDLE. Reset asserted mid-transaction aborts it on the same edge, with no ack.

## Timing
- Let E0 be the edge at which the hit is sampled.
- Write: csb/web low from E0 to E1; SRAM captures at E1; ack high from E1 to E2. Ack appears 2 edges after E0.
- Read: csb low from E0 to E1; SRAM captures at E1; `wb_rom_val` is valid before E2 and is registered at E2; ack and data are valid from E2 to E3. Ack appears 3 edges after E0.
- Ack is exactly one cycle wide. A new request is accepted no earlier than the edge after ACK, so back-to-back transactions take 3 cycles (write) or 4 cycles (read).
- `rom_lock` is sampled only at E0. Changes during a transaction have no effect on it.

## Configuration
- `WB_ROM_READBACK_EN` defined: reads follow the RD/RD_WAIT path above.
- Not defined: a read hit goes IDLE→ACK directly, csb stays 1, `wbs_dat_o`=0, and ack appears 1 edge after E0. The RD and RD_WAIT states are not built.

## Test plan
- Reset: hold `wb_rst_i` for 2 cycles -> ack=0, dat_o=0, csb=1, web=1, adrb=0.
- Write 0xDEADBEEF to 0x3000_0010 with sel=4'hF -> one cycle with csb=0, web=0, adrb=4, wmask=F, din=DEADBEEF; ack 2 edges after E0; ack high for one cycle.
- With readback enabled, read 0x3000_0010 with the model returning 0xDEADBEEF -> csb low for one cycle with web=1; ack and dat_o=DEADBEEF 3 edges after E0. Without the macro -> ack at 1 edge, dat_o=0, csb never low.
- Byte write sel=4'b0100 of 0x00AA0000, then read -> wmask=4; the model word's byte 2 becomes 0xAA and all other bytes are unchanged.
- `rom_lock`=1 write to 0x3000_07FC -> ack at 2 edges, csb stays 1 throughout, memory unchanged.
- Access to 0x3000_0800 -> no ack and no csb activity. `wbs_cyc_i` dropped during RD -> no ack and FSM back in IDLE. Reset asserted in RD_WAIT -> ack never asserted.
